regfile_burst_master: RTL and testbench

REGFILE_BURST_MASTER -- requirements
Module: regfile_burst_master

---
 rtl/regfile_burst_master.sv | 157 +++++++++++++++
 tb/tb_regfile_burst_master.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_burst_master.sv
// Burst master moving 64-bit beats between a stream interface and a 32-entry register file.
// One command either writes a burst of registers or reads one back as a handshaked stream.
module regfile_burst_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_base,
    input  logic [5:0]  cmd_count,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [63:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [63:0] rd_data,
    output logic        rd_last,
    output logic        done,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData,
    output logic [4:0]  ReadRegister1,
    input  logic [63:0] ReadData1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  addr_q, addr_d;
    logic [5:0]  remaining_q, remaining_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  write_register_q, write_register_d;
    logic [63:0] write_data_q, write_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic [63:0] rd_data_q, rd_data_d;
    logic        rd_last_q, rd_last_d;
    logic        done_q, done_d;

    // State and output registers, cleared synchronously.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            addr_q           <= 5'd0;
            remaining_q      <= 6'd0;
            reg_write_q      <= 1'b0;
            write_register_q <= 5'd0;
            write_data_q     <= 64'd0;
            rd_valid_q       <= 1'b0;
            rd_data_q        <= 64'd0;
            rd_last_q        <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            remaining_q      <= remaining_d;
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            rd_valid_q       <= rd_valid_d;
            rd_data_q        <= rd_data_d;
            rd_last_q        <= rd_last_d;
            done_q           <= done_d;
        end
    end

    // Next-state logic for command acceptance, write beats and read beats.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        remaining_d      = remaining_q;
        reg_write_d      = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        rd_valid_d       = rd_valid_q;
        rd_data_d        = rd_data_q;
        rd_last_d        = rd_last_q;
        done_d           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_base;
                    remaining_d = cmd_count;
                    if (cmd_count == 6'd0) begin
                        done_d = 1'b1;
                    end else if (cmd_write) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_valid) begin
                    reg_write_d      = 1'b1;
                    write_register_d = addr_q;
                    write_data_d     = wr_data;
                    addr_d           = addr_q + 5'd1;
                    remaining_d      = remaining_q - 6'd1;
                    if (remaining_q == 6'd1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                // Retire the presented beat first; a new capture below may refill the slot.
                if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (rd_last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
                if ((remaining_q != 6'd0) && (!rd_valid_q || rd_ready)) begin
                    rd_valid_d  = 1'b1;
                    rd_data_d   = ReadData1;
                    rd_last_d   = (remaining_q == 6'd1);
                    addr_d      = addr_q + 5'd1;
                    remaining_d = remaining_q - 6'd1;
                end else begin
                    remaining_d = remaining_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign wr_ready      = (state_q == ST_WRITE);
    assign ReadRegister1 = (state_q == ST_READ) ? addr_q : 5'd0;
    assign RegWrite      = reg_write_q;
    assign WriteRegister = write_register_q;
    assign WriteData     = write_data_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign rd_last       = rd_last_q;
    assign done          = done_q;

endmodule

// File: tb/tb_regfile_burst_master.sv
// Directed bench for regfile_burst_master with a falling-edge register-file model
// in which index 31 always reads zero and discards writes.
module tb_regfile_burst_master;

    logic        clk = 1'b0;
    logic        reset, cmd_valid, cmd_write, wr_valid, rd_ready;
    logic [4:0]  cmd_base;
    logic [5:0]  cmd_count;
    logic [63:0] wr_data;
    logic        cmd_ready, wr_ready, rd_valid, rd_last, done, RegWrite;
    logic [63:0] rd_data, WriteData, ReadData1;
    logic [4:0]  WriteRegister, ReadRegister1;

    logic [63:0] rf [0:31];
    logic [63:0] wd [0:7];
    logic [63:0] rx [0:7];
    int checks = 0;
    int errors = 0;
    int rw_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    regfile_burst_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadData1(ReadData1)
    );

    // Register file commits on the falling edge; index 31 is hardwired to zero.
    always @(negedge clk) begin
        if (RegWrite && WriteRegister != 5'd31) rf[WriteRegister] <= WriteData;
        if (RegWrite) rw_cnt <= rw_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end
    assign ReadData1 = rf[ReadRegister1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [4:0] base, input logic [5:0] cnt);
        cmd_valid = 1'b1; cmd_write = wr; cmd_base = base; cmd_count = cnt;
        chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [4:0] base, input int cnt);
        int rw0;
        logic [4:0] idx;
        rw0 = rw_cnt;
        issue(1'b1, base, cnt[5:0]);
        for (int i = 0; i < cnt; i++) begin
            wr_valid = 1'b1; wr_data = wd[i];
            chk("wr_ready", {63'd0, wr_ready}, 64'd1);
            step();
            idx = base + i[4:0];
            chk("regwrite", {63'd0, RegWrite}, 64'd1);
            chk("write_reg", {59'd0, WriteRegister}, {59'd0, idx});
            chk("write_data", WriteData, wd[i]);
            chk("wr_done", {63'd0, done}, {63'd0, (i == cnt - 1)});
        end
        wr_valid = 1'b0;
        chk("wr_ready_off", {63'd0, wr_ready}, 64'd0);
        step();
        chk("regwrite_off", {63'd0, RegWrite}, 64'd0);
        chk("wr_total", rw_cnt - rw0, cnt);
    endtask

    task automatic read_burst(input logic [4:0] base, input int cnt, input logic toggle);
        int n, cyc, d0;
        logic prev_stall;
        logic [63:0] prev_data;
        n = 0; cyc = 0; prev_stall = 1'b0; prev_data = 64'd0; d0 = done_cnt;
        issue(1'b0, base, cnt[5:0]);
        while (n < cnt && cyc < 200) begin
            rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (prev_stall) begin
                chk("rd_hold_valid", {63'd0, rd_valid}, 64'd1);
                chk("rd_hold_data", rd_data, prev_data);
            end
            if (rd_valid && rd_ready) begin
                chk("rd_data", rd_data, rx[n]);
                chk("rd_last", {63'd0, rd_last}, {63'd0, (n == cnt - 1)});
                n++;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data = rd_data;
            step();
            cyc++;
        end
        if (n < cnt) chk("rd_timeout", n, cnt);
        rd_ready = 1'b0;
        chk("rd_done", {63'd0, done}, 64'd1);
        chk("rd_valid_off", {63'd0, rd_valid}, 64'd0);
        chk("rd_done_once", done_cnt - d0, 0);
        step();
        chk("rd_done_pulse", {63'd0, done}, 64'd0);
        chk("rd_done_total", done_cnt - d0, 1);
    endtask

    initial begin
        int rw0, d0;
        for (int i = 0; i < 32; i++) rf[i] = 64'd0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = 5'd0; cmd_count = 6'd0;
        wr_valid = 1'b0; wr_data = 64'd0; rd_ready = 1'b0;
        step(); step();
        chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("rst_wreg", {59'd0, WriteRegister}, 64'd0);
        chk("rst_wdata", WriteData, 64'd0);
        chk("rst_rreg", {59'd0, ReadRegister1}, 64'd0);
        chk("rst_rd", {62'd0, rd_valid, rd_last}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_done_wr_ready", {62'd0, done, wr_ready}, 64'd0);
        reset = 1'b0;
        step();
        chk("cmd_ready_after_rst", {63'd0, cmd_ready}, 64'd1);

        // Back-to-back write then read of regs 3..6
        wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
        write_burst(5'd3, 4);
        rx[0] = 64'h11; rx[1] = 64'h22; rx[2] = 64'h33; rx[3] = 64'h44;
        read_burst(5'd3, 4, 1'b0);

        // Wrap across index 31 (discarded by the register file) to index 0
        wd[0] = 64'hA; wd[1] = 64'hB; wd[2] = 64'hC;
        write_burst(5'd30, 3);
        rx[0] = 64'hA; rx[1] = 64'h0; rx[2] = 64'hC;
        read_burst(5'd30, 3, 1'b0);

        // Eight-beat read with rd_ready toggling every cycle
        for (int i = 0; i < 8; i++) begin
            wd[i] = 64'h1000_0000_0000_0100 + 64'(i);
            rx[i] = wd[i];
        end
        write_burst(5'd16, 8);
        read_burst(5'd16, 8, 1'b1);

        // Zero-length commands
        rw0 = rw_cnt; d0 = done_cnt;
        issue(1'b0, 5'd5, 6'd0);
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("zero_rd_valid", {63'd0, rd_valid}, 64'd0);
        issue(1'b1, 5'd5, 6'd0);
        chk("zero_done_w", {63'd0, done}, 64'd1);
        chk("zero_wr_ready", {63'd0, wr_ready}, 64'd0);
        step();
        chk("zero_done_end", {63'd0, done}, 64'd0);
        chk("zero_no_write", rw_cnt - rw0, 0);
        chk("zero_done_cnt", done_cnt - d0, 2);

        // Ignored write beats while idle
        rw0 = rw_cnt;
        wr_valid = 1'b1; wr_data = 64'hDEAD;
        step(); step();
        wr_valid = 1'b0;
        chk("idle_wr_ignored", rw_cnt - rw0, 0);

        // Reset after two of five write beats
        rw0 = rw_cnt; d0 = done_cnt;
        issue(1'b1, 5'd8, 6'd5);
        wr_valid = 1'b1; wr_data = 64'h8080;
        step();
        wr_data = 64'h9090;
        step();
        wr_data = 64'hA0A0;
        reset = 1'b1;
        step();
        chk("abort_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("abort_wr_ready", {63'd0, wr_ready}, 64'd0);
        reset = 1'b0;
        wr_data = 64'hB0B0;
        step();
        chk("abort_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        step();
        wr_valid = 1'b0;
        chk("abort_writes", rw_cnt - rw0, 2);
        chk("abort_no_done", done_cnt - d0, 0);
        rx[0] = 64'h8080; rx[1] = 64'h9090; rx[2] = 64'h0; rx[3] = 64'h0; rx[4] = 64'h0;
        read_burst(5'd8, 5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
